// File: rtl/pwm_capture_if.sv
// Bundle between a PWM source/result consumer and pwm_capture.
// The master modport drives pwm_in and reads the measurement; the slave modport is the capture block.
interface pwm_capture_if #(
  parameter int CBITS = 16
);
  logic             pwm_in;
  logic [CBITS-1:0] high_time;
  logic [CBITS-1:0] period;
  logic             valid;
  logic             saturated;
  logic             stuck;

  modport master (
    output pwm_in,
    input  high_time,
    input  period,
    input  valid,
    input  saturated,
    input  stuck
  );

  modport slave (
    input  pwm_in,
    output high_time,
    output period,
    output valid,
    output saturated,
    output stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rising-to-rising period of pwm_in in clk cycles.
// Optional stuck-level timeout reporting is enabled by defining PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture #(
  parameter int          CBITS   = 16,
  parameter int unsigned TIMEOUT = 32'hFFF0
) (
  input  logic         clk,
  input  logic         reset,
  pwm_capture_if.slave cap
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MEAS_HIGH = 2'd1;
  localparam logic [1:0] MEAS_LOW  = 2'd2;

  localparam logic [CBITS-1:0] CNT_ONE = {{(CBITS-1){1'b0}}, 1'b1};

  // A nonsensical TIMEOUT would either fire instantly or never.
  if (TIMEOUT < 2 || longint'(TIMEOUT) >= (longint'(1) << CBITS) - 1) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT out of range");
  end

  // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3 (previous s2)
  logic [2:0]       sync_reg;
  logic             s2;
  logic             rise;
  logic             fall;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CBITS-1:0] cnt_reg;
  logic [CBITS-1:0] cnt_next;
  logic [CBITS-1:0] cnt_inc;
  logic             cnt_max;
  logic             sat_reg;
  logic             sat_next;
  logic [CBITS-1:0] hsnap_reg;
  logic [CBITS-1:0] hsnap_next;

  logic             report;
  logic [CBITS-1:0] rep_high;
  logic [CBITS-1:0] rep_period;
  logic             rep_sat;
  logic             rep_stuck;

  logic [CBITS-1:0] high_time_reg;
  logic [CBITS-1:0] period_reg;
  logic             valid_reg;
  logic             saturated_reg;
  logic             stuck_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], cap.pwm_in};
    end
  end

  assign s2   = sync_reg[1];
  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

  assign cnt_max = &cnt_reg;
  assign cnt_inc = cnt_max ? cnt_reg : cnt_reg + CNT_ONE;

`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam logic [CBITS-1:0] TIMEOUT_C = TIMEOUT[CBITS-1:0];
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sat_next   = sat_reg;
    hsnap_next = hsnap_reg;
    report     = 1'b0;
    rep_high   = hsnap_reg;
    rep_period = cnt_reg;
    rep_sat    = sat_reg | cnt_max;
    rep_stuck  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = MEAS_HIGH;
          cnt_next   = CNT_ONE;
          sat_next   = 1'b0;
        end
      end

      MEAS_HIGH: begin
        cnt_next = cnt_inc;
        sat_next = sat_reg | cnt_max;
        // The first low cycle sees cnt equal to the number of high cycles.
        if (fall) begin
          hsnap_next = cnt_reg;
          state_next = MEAS_LOW;
        end
      end

      MEAS_LOW: begin
        if (rise) begin
          report     = 1'b1;
          state_next = MEAS_HIGH;
          cnt_next   = CNT_ONE;
          sat_next   = 1'b0;
        end else begin
          cnt_next = cnt_inc;
          sat_next = sat_reg | cnt_max;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef PWM_CAPTURE_TIMEOUT_EN
    // An edge in the same cycle wins over the timeout.
    if (state_reg != IDLE && cnt_reg == TIMEOUT_C && !rise && !fall) begin
      report     = 1'b1;
      rep_period = TIMEOUT_C;
      rep_high   = s2 ? TIMEOUT_C : hsnap_reg;
      rep_sat    = 1'b0;
      rep_stuck  = 1'b1;
      state_next = IDLE;
      cnt_next   = cnt_reg;
      sat_next   = sat_reg;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sat_reg   <= 1'b0;
      hsnap_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sat_reg   <= sat_next;
      hsnap_reg <= hsnap_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_time_reg <= '0;
      period_reg    <= '0;
      valid_reg     <= 1'b0;
      saturated_reg <= 1'b0;
      stuck_reg     <= 1'b0;
    end else begin
      valid_reg <= report;
      if (report) begin
        high_time_reg <= rep_high;
        period_reg    <= rep_period;
        saturated_reg <= rep_sat;
        stuck_reg     <= rep_stuck;
      end
    end
  end

`ifndef PWM_CAPTURE_TIMEOUT_EN
  // s2 only feeds the timeout path; keep it referenced in the default build.
  logic s2_unused;
  assign s2_unused = s2;
`endif

  assign cap.high_time = high_time_reg;
  assign cap.period    = period_reg;
  assign cap.valid     = valid_reg;
  assign cap.saturated = saturated_reg;
  assign cap.stuck     = stuck_reg;

endmodule
